tb_timer: RTL and testbench
===========================

Name: tb_timer

Overview:
- Testbench down-counting timer peripheral with a Wishbone slave register interface.
- Sits directly upstream of the testbench interrupt controller; its o_irq drives one bit of the controller's interrupt-source input.
- Gives CPU tests a programmable periodic or one-shot interrupt source for exercising the interrupt path.

Parameters:
- CNT_W, 32: counter and LOAD width, 1..32. Reads are zero-extended to 32 bits; writes take the low CNT_W bits.

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_wb_dat  input  32  write data
- i_wb_adr  input  4  byte address: 0x0 CTRL, 0x4 LOAD, 0x8 COUNT, 0xC STATUS
- i_wb_stb  input  1  strobe
- i_wb_cyc  input  1  cycle
- i_wb_wen  input  1  1 = write, 0 = read
- i_wb_sel  input  4  byte lane enables, used on writes
- o_wb_dat  output  32  read data, registered
- o_wb_ack  output  1  single-cycle acknowledge, registered
- o_irq  output  1  level interrupt, registered

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - Bus outputs: o_wb_dat=0, o_wb_ack=0, o_irq=0.
  - Registers: CTRL=0, LOAD=0, COUNT=0, EXPIRED=0.
  - Bus FSM returns to IDLE; an in-flight transfer is dropped with no ack.
- Registers:
  - CTRL[0] EN: counter runs.
  - CTRL[1] PERIODIC: 1 = auto-reload, 0 = one-shot.
  - CTRL[2] IE: interrupt enable.
  - CTRL[15:8] PRE: prescale, see Optional Feature.
  - Other CTRL bits read 0.
  - LOAD: reload value. Writing LOAD also copies the written value into COUNT on the same edge.
  - COUNT: read-only; writes are ignored.
  - STATUS[0] EXPIRED: writing 1 clears it; writing 0 has no effect.
  - Unmapped addresses: reads return 0, writes are ignored.
  - Byte lanes gate every register write.
- Bus FSM states: IDLE, READ, WRITE, ACK.
  - IDLE -> WRITE or READ when i_wb_stb & i_wb_cyc & !o_wb_ack, selected by i_wb_wen.
  - WRITE: register update happens on the exit edge -> ACK.
  - READ: o_wb_dat is loaded on the exit edge -> ACK.
  - ACK: sets o_wb_ack=1 -> IDLE.
  - IDLE clears o_wb_ack.
  - Ack rises 3 cycles after the request is sampled and stays high for exactly 1 cycle.
  - The !o_wb_ack guard prevents a retrigger while the master is still dropping stb.
- Counter, evaluated on each tick while EN=1:
  - COUNT!=0: COUNT decrements by 1.
  - COUNT==0: EXPIRED<=1. If PERIODIC=1, COUNT<=LOAD; if PERIODIC=0, EN<=0 and COUNT stays 0.
- Counter boundary conditions:
  - LOAD=0 with PERIODIC=1: EXPIRED is set on every tick.
  - Period is LOAD+1 ticks.
  - EN=0: COUNT holds its value.
  - Setting EN does not reload COUNT.
- o_irq <= EXPIRED & IE, registered, so it lags EXPIRED by 1 cycle.
  - Clearing IE drops o_irq next cycle; EXPIRED is kept.
- Simultaneous events:
  - Expiry and a STATUS clear on the same edge: the set wins (no lost event).
  - LOAD write and a tick on the same edge: the LOAD write wins (COUNT takes the new value, no decrement).
  - A CTRL write clearing EN on the same edge as a one-shot expiry still sets EXPIRED.

Optional Feature:
- Macro: TB_TIMER_PRESCALER_EN.
- Defined:
  - An 8-bit prescale counter generates one tick every PRE+1 clocks while EN=1.
  - The prescale counter resets to 0 on any CTRL write or when EN=0.
  - PRE is readable and writable.
- Undefined:
  - Tick occurs every clock while EN=1.
  - CTRL[15:8] writes are ignored and the field reads 0.

Test Plan:
- Reset, then read 0x0/0x4/0x8/0xC -> all return 0; o_irq=0; each ack is a single-cycle pulse 3 cycles after stb.
- Write LOAD=5, CTRL=0x7 (EN, PERIODIC, IE) -> EXPIRED set every 6 cycles; o_irq rises 1 cycle after EXPIRED; COUNT sequence 5,4,3,2,1,0,5.
- One-shot: LOAD=3, CTRL=0x5 -> single expiry; CTRL reads 0x4 afterwards; COUNT reads 0; o_irq stays high until STATUS write 0x1.
- Periodic with LOAD=0 and STATUS clear timed to coincide with an expiry -> EXPIRED reads 1 (set wins); o_irq never drops.
- Write CTRL with i_wb_sel=4'b0000, then write to address 0x8 -> no register changes; read of 0x8 returns the running COUNT; an unmapped write is ignored.
- With TB_TIMER_PRESCALER_EN defined: LOAD=2, CTRL=0x0307 -> expiry every 12 clocks. Also drive i_rst_n low mid-transfer -> no ack issued and all outputs 0 asynchronously.

Source files
------------

// File: rtl/tb_timer.sv
// tb_timer: Wishbone down-counting timer with periodic/one-shot interrupt; define TB_TIMER_PRESCALER_EN to enable the CTRL[15:8] prescaler
module tb_timer #(
   parameter int CNT_W = 32
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_adr,
   input  logic        i_wb_stb,
   input  logic        i_wb_cyc,
   input  logic        i_wb_wen,
   input  logic [3:0]  i_wb_sel,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_ack,
   output logic        o_irq
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, ACK} state_t;
   state_t state, state_nxt;
   logic [31:0] req_dat;
   logic [3:0] req_adr, req_sel;
   logic en, periodic, ie, expired;
   logic [7:0] pre;
   logic [CNT_W-1:0] load, count;
   logic [31:0] load_ext, count_ext, load_mrg, rd_dat;
   logic wr, ctrl_wr, load_wr, stat_clr, tick, fire;
   assign load_ext = 32'(load);
   assign count_ext = 32'(count);
`ifdef TB_TIMER_PRESCALER_EN
   logic [7:0] psc;
   assign tick = en && psc == pre;
   // prescale counter restarts on CTRL writes and while stopped, wraps on each tick
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) psc <= '0;
      else psc <= (ctrl_wr || !en || tick) ? '0 : psc + 8'd1;
   // prescale field is written through byte lane 1 of CTRL
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) pre <= '0;
      else if (ctrl_wr && req_sel[1]) pre <= req_dat[15:8];
`else
   assign tick = en;
   assign pre = 8'd0;
`endif
   // bus next state, write strobes and read mux
   always_comb begin
      state_nxt = state == IDLE ? (i_wb_stb && i_wb_cyc && !o_wb_ack ? (i_wb_wen ? WRITE : READ) : IDLE) : state == ACK ? IDLE : ACK;
      wr = state == WRITE;
      ctrl_wr = wr && req_adr == 4'h0 && |req_sel;
      load_wr = wr && req_adr == 4'h4 && |req_sel;
      stat_clr = wr && req_adr == 4'hC && req_sel[0] && req_dat[0];
      fire = tick && count == '0;
      load_mrg = load_ext;
      for (int b = 0; b < 4; b++) if (req_sel[b]) load_mrg[8*b +: 8] = req_dat[8*b +: 8];
      rd_dat = req_adr == 4'h0 ? {16'd0, pre, 5'd0, ie, periodic, en} :
               req_adr == 4'h4 ? load_ext :
               req_adr == 4'h8 ? count_ext :
               req_adr == 4'hC ? {31'd0, expired} : 32'd0;
   end
   // bus state register, request capture in IDLE, registered read data and ack
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state <= IDLE;
         req_dat <= '0;
         req_adr <= '0;
         req_sel <= '0;
         o_wb_dat <= '0;
         o_wb_ack <= 1'b0;
      end else begin
         state <= state_nxt;
         o_wb_ack <= state == ACK;
         if (state == READ) o_wb_dat <= rd_dat;
         if (state == IDLE) begin
            req_dat <= i_wb_dat;
            req_adr <= i_wb_adr;
            req_sel <= i_wb_sel;
         end
      end
   // timer registers: LOAD write beats a tick, expiry beats a STATUS clear
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         en <= 1'b0;
         periodic <= 1'b0;
         ie <= 1'b0;
         load <= '0;
         count <= '0;
         expired <= 1'b0;
         o_irq <= 1'b0;
      end else begin
         if (ctrl_wr && req_sel[0]) begin
            en <= req_dat[0];
            periodic <= req_dat[1];
            ie <= req_dat[2];
         end else if (fire && !periodic) en <= 1'b0;
         if (load_wr) load <= load_mrg[CNT_W-1:0];
         count <= load_wr ? load_mrg[CNT_W-1:0] : !tick ? count : count != '0 ? count - CNT_W'(1) : periodic ? load : count;
         expired <= fire ? 1'b1 : stat_clr ? 1'b0 : expired;
         o_irq <= expired && ie;
      end
endmodule

// File: tb/tb_tb_timer.sv
// tb_tb_timer: directed and randomized Wishbone traffic checked each cycle against a behavioural timer model
`timescale 1ns/1ps
module tb_tb_timer;
   localparam int CW = 32;
   localparam logic [31:0] MASK = (CW == 32) ? 32'hFFFF_FFFF : ((32'd1 << CW) - 32'd1);
`ifdef TB_TIMER_PRESCALER_EN
   localparam bit PSC = 1'b1;
`else
   localparam bit PSC = 1'b0;
`endif
   logic clk = 1'b0, rst_n = 1'b0;
   logic [31:0] wdat = '0;
   logic [3:0] adr = '0, sel = '0;
   logic stb = 1'b0, cyc = 1'b0, wen = 1'b0;
   logic [31:0] rdat;
   logic ack, irq;
   int total = 0, bad = 0;
   bit watch = 0, dropped = 0;

   tb_timer #(.CNT_W(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_wb_dat(wdat), .i_wb_adr(adr), .i_wb_stb(stb),
      .i_wb_cyc(cyc), .i_wb_wen(wen), .i_wb_sel(sel), .o_wb_dat(rdat), .o_wb_ack(ack), .o_irq(irq)
   );

   always #5 clk = ~clk;

   // behavioural model: register contents plus the bus timing "effect one edge after sampling, ack the edge after"
   logic m_en = 0, m_per = 0, m_ie = 0, m_exp = 0, m_irq = 0, m_ack = 0;
   logic [31:0] m_load = 0, m_count = 0, m_rdat = 0;
   int m_pre = 0, m_psc = 0, age = -1;
   logic [31:0] l_dat = 0;
   logic [3:0] l_adr = 0, l_sel = 0;
   logic l_wen = 0;

   function automatic logic [31:0] read_reg(input logic [3:0] a);
      case (a)
         4'h0: return {16'd0, 8'(m_pre), 5'd0, m_ie, m_per, m_en};
         4'h4: return m_load;
         4'h8: return m_count;
         4'hC: return {31'd0, m_exp};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_step();
      bit tick, fire, wr, ctrl, wl, n_irq, n_ack;
      logic [31:0] merged;
      tick = m_en && (!PSC || m_psc == m_pre);
      fire = tick && m_count == 0;
      wr = age == 0 && l_wen;
      if (age == 0 && !l_wen) m_rdat = read_reg(l_adr);
      ctrl = wr && l_adr == 4'h0 && l_sel != 0;
      wl = wr && l_adr == 4'h4 && l_sel != 0;
      merged = m_load;
      for (int b = 0; b < 4; b++) if (l_sel[b]) merged[8*b +: 8] = l_dat[8*b +: 8];
      n_irq = m_exp && m_ie;
      n_ack = age == 1;
      m_psc = (ctrl || !m_en || tick) ? 0 : m_psc + 1;
      if (wl) m_count = merged & MASK;
      else if (tick) m_count = m_count != 0 ? m_count - 1 : (m_per ? m_load : 0);
      if (wl) m_load = merged & MASK;
      if (fire) m_exp = 1;
      else if (wr && l_adr == 4'hC && l_sel[0] && l_dat[0]) m_exp = 0;
      if (ctrl && l_sel[0]) {m_ie, m_per, m_en} = l_dat[2:0];
      else if (fire && !m_per) m_en = 0;
      if (PSC && ctrl && l_sel[1]) m_pre = int'(l_dat[15:8]);
      if (age == 1) age = -1;
      else if (age == 0) age = 1;
      else if (stb && cyc && !m_ack) begin
         age = 0;
         l_adr = adr;
         l_dat = wdat;
         l_sel = sel;
         l_wen = wen;
      end
      m_irq = n_irq;
      m_ack = n_ack;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         {m_en, m_per, m_ie, m_exp, m_irq, m_ack} = '0;
         m_load = 0; m_count = 0; m_rdat = 0; m_pre = 0; m_psc = 0; age = -1;
      end else model_step();
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) if (rst_n) begin
      total++;
      if (irq !== m_irq) begin bad++; $display("FAIL irq: got %0b want %0b at %0t", irq, m_irq, $time); end
      total++;
      if (ack !== m_ack) begin bad++; $display("FAIL ack: got %0b want %0b at %0t", ack, m_ack, $time); end
      total++;
      if (rdat !== m_rdat) begin bad++; $display("FAIL rdat: got %h want %h at %0t", rdat, m_rdat, $time); end
      if (watch && !irq) dropped = 1;
   end

   task automatic xfer(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] q);
      int n = 0;
      stb = 1; cyc = 1; wen = w; adr = a; wdat = d; sel = s;
      do begin @(negedge clk); n++; end while (!ack && n < 10);
      total++;
      if (!ack || n != 4) begin bad++; $display("FAIL ack_latency: got %0d want 4 negedges (ack=%0b)", n, ack); end
      q = rdat;
      @(posedge clk); #1;
      stb = 0; cyc = 0; wen = 0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
      logic [31:0] q;
      xfer(1'b1, a, d, s, q);
   endtask

   task automatic rd_chk(input logic [3:0] a, input logic [31:0] e, input string nm);
      logic [31:0] q;
      xfer(1'b0, a, 32'd0, 4'hF, q);
      total++;
      if (q !== e) begin bad++; $display("FAIL %s: got %h want %h", nm, q, e); end
   endtask

   task automatic lit(input logic got, input logic want, input string nm);
      total++;
      if (got !== want) begin bad++; $display("FAIL %s: got %0b want %0b", nm, got, want); end
   endtask

   task automatic wait_irq(input int want, input string nm);
      int n = 0;
      while (!irq && n < 40) begin @(posedge clk); #1; n++; end
      total++;
      if (n != want) begin bad++; $display("FAIL %s: got %0d want %0d cycles", nm, n, want); end
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] q;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;
      lit(irq, 1'b0, "reset_irq");
      rd_chk(4'h0, 32'd0, "reset_ctrl");
      rd_chk(4'h4, 32'd0, "reset_load");
      rd_chk(4'h8, 32'd0, "reset_count");
      rd_chk(4'hC, 32'd0, "reset_status");
      // periodic, LOAD=5: first irq 6 ticks after enabling, then one expiry every 6 ticks
      wr(4'h0, 32'h6);
      wr(4'h4, 32'd5);
      wr(4'h0, 32'h7);
      wait_irq(5, "periodic_first_irq");
      rd_chk(4'hC, 32'd1, "periodic_status");
      repeat (30) @(posedge clk);
      #1;
`ifdef TB_TIMER_PRESCALER_EN
      // prescaler 3, LOAD=2: expiry every 12 clocks
      wr(4'h0, 32'h0306);
      wr(4'hC, 32'h1);
      wr(4'h4, 32'd2);
      wr(4'h0, 32'h0307);
      wait_irq(11, "prescale_first_irq");
      rd_chk(4'h0, 32'h0307, "prescale_ctrl");
      repeat (40) @(posedge clk);
      #1;
`endif
      // one-shot LOAD=3
      wr(4'h0, 32'h0);
      wr(4'hC, 32'h1);
      wr(4'h4, 32'd3);
      wr(4'h0, 32'h5);
      repeat (10) @(posedge clk);
      #1;
      rd_chk(4'h0, 32'h4, "oneshot_ctrl");
      rd_chk(4'h8, 32'd0, "oneshot_count");
      rd_chk(4'hC, 32'd1, "oneshot_status");
      lit(irq, 1'b1, "oneshot_irq_held");
      wr(4'hC, 32'h1);
      lit(irq, 1'b0, "oneshot_irq_cleared");
      rd_chk(4'hC, 32'd0, "oneshot_status_cleared");
      // LOAD=0 periodic: expiry every tick, so a clear always collides with a set
      wr(4'h0, 32'h0);
      wr(4'h4, 32'd0);
      wr(4'h0, 32'h7);
      lit(irq, 1'b1, "load0_irq");
      watch = 1;
      wr(4'hC, 32'h1);
      rd_chk(4'hC, 32'd1, "set_wins_status");
      watch = 0;
      lit(dropped, 1'b0, "set_wins_irq_never_drops");
      // byte lanes, read-only COUNT, unmapped address
      wr(4'h0, 32'h0, 4'h0);
      rd_chk(4'h0, 32'h7, "sel0_ctrl_unchanged");
      wr(4'h4, 32'd100);
      wr(4'h8, 32'hFFFF);
      repeat (3) begin xfer(1'b0, 4'h8, 32'd0, 4'hF, q); end
      wr(4'h2, 32'hFFFF_FFFF);
      rd_chk(4'h2, 32'd0, "unmapped_read");
      rd_chk(4'h0, 32'h7, "unmapped_write_ignored");
      wr(4'h4, 32'hAABB_CCDD, 4'b0101);
      rd_chk(4'h4, 32'h00BB_00DD, "partial_lane_load");
      // randomized traffic checked by the model
      for (int i = 0; i < 300; i++) begin
         logic [3:0] a;
         logic [31:0] d;
         int k;
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         k = $urandom_range(0, 5);
         a = k == 0 ? 4'h0 : k == 1 ? 4'h4 : k == 2 ? 4'h8 : k == 3 ? 4'hC : 4'($urandom);
         d = a == 4'h0 ? ((32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 7))) : a == 4'h4 ? 32'($urandom_range(0, 12)) : $urandom;
         xfer(1'($urandom), a, d, $urandom_range(0, 4) != 0 ? 4'hF : 4'($urandom), q);
      end
      // asynchronous reset in the middle of a read
      wr(4'h0, 32'h7);
      wr(4'h4, 32'd0);
      rd_chk(4'h0, 32'h7, "pre_reset_ctrl");
      stb = 1; cyc = 1; wen = 0; adr = 4'h8; sel = 4'hF;
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      lit(ack, 1'b0, "async_reset_ack");
      lit(irq, 1'b0, "async_reset_irq");
      total++;
      if (rdat !== 32'd0) begin bad++; $display("FAIL async_reset_rdat: got %h want 0", rdat); end
      stb = 0; cyc = 0;
      begin
         bit seen = 0;
         repeat (5) begin @(negedge clk); if (ack) seen = 1; end
         lit(seen, 1'b0, "dropped_transfer_no_ack");
      end
      @(posedge clk);
      #1 rst_n = 1;
      rd_chk(4'h0, 32'd0, "post_reset_ctrl");
      rd_chk(4'hC, 32'd0, "post_reset_status");
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
